// File: rtl/led_pattern_gen_if.sv
// Config write port for led_pattern_gen: valid/ready handshake plus channel, mode and parameters.
// Master drives the request fields and the slave returns cfg_ready.
interface led_pattern_gen_if #(
    parameter int CNT_WIDTH = 24,
    parameter int PWM_WIDTH = 8
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [3:0]           cfg_chan;
    logic [1:0]           cfg_mode;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [PWM_WIDTH-1:0] cfg_duty;

    modport master (
        output cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator (OFF/ON/BLINK/PWM); LED_BREATHE_EN makes PWM duty ramp.
// Latency: write at edge k drives LED from edge k+1; BLINK P first rises at k+P+2.
// Backpressure: cfg_ready is low only in the first cycle after reset, then accepts every cycle.
module led_pattern_gen #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 24,
    parameter int PWM_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  BTN1,
    led_pattern_gen_if.slave      cfg,
    output logic [CHANNELS-1:0]   LED,
    output logic                  pwm_tick
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    typedef struct packed {
        mode_t                mode;
        logic [CNT_WIDTH-1:0] period;
        logic [CNT_WIDTH-1:0] cnt;
        logic [PWM_WIDTH-1:0] duty;
        logic                 state;
    } chan_t;

    localparam logic [PWM_WIDTH-1:0] PWM_ONE  = PWM_WIDTH'(1);
    localparam logic [PWM_WIDTH-1:0] PWM_MAX  = '1;
    localparam logic [PWM_WIDTH-1:0] PWM_WRAP = {{(PWM_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    chan_t                ch [CHANNELS];
    logic                 ready_q;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [CHANNELS-1:0]  wrap;
    logic [CHANNELS-1:0]  cnt_en;
    logic                 wr_en;

`ifdef LED_BREATHE_EN
    logic [CHANNELS-1:0]  dir_dn;
`endif

    assign cfg.cfg_ready = ready_q;
    assign wr_en         = cfg.cfg_valid && ready_q;

    always_comb begin
        wrap   = '0;
        cnt_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i] = (ch[i].cnt == ch[i].period);
`ifdef LED_BREATHE_EN
            cnt_en[i] = (ch[i].mode == MODE_BLINK) || (ch[i].mode == MODE_PWM);
`else
            cnt_en[i] = (ch[i].mode == MODE_BLINK);
`endif
        end
    end

    always_ff @(posedge CLK or negedge BTN1) begin
        if (!BTN1) begin
            ready_q  <= 1'b0;
            pwm_cnt  <= '0;
            pwm_tick <= 1'b0;
            LED      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                ch[i] <= '0;
`ifdef LED_BREATHE_EN
                dir_dn[i] <= 1'b0;
`endif
            end
        end else begin
            ready_q <= 1'b1;

            // Frame is 2^PWM_WIDTH-1 cycles so that the all-ones duty is fully on.
            if (pwm_cnt == PWM_WRAP) begin
                pwm_cnt  <= '0;
                pwm_tick <= 1'b1;
            end else begin
                pwm_cnt  <= pwm_cnt + PWM_ONE;
                pwm_tick <= 1'b0;
            end

            for (int i = 0; i < CHANNELS; i++) begin
                case (ch[i].mode)
                    MODE_OFF:   LED[i] <= 1'b0;
                    MODE_ON:    LED[i] <= 1'b1;
                    MODE_BLINK: LED[i] <= ch[i].state;
                    MODE_PWM:   LED[i] <= (pwm_cnt < ch[i].duty);
                    default:    LED[i] <= 1'b0;
                endcase

                if (cnt_en[i]) begin
                    if (wrap[i]) begin
                        ch[i].cnt <= '0;
                        if (ch[i].mode == MODE_BLINK)
                            ch[i].state <= ~ch[i].state;
                    end else begin
                        ch[i].cnt <= ch[i].cnt + CNT_ONE;
                    end
                end

`ifdef LED_BREATHE_EN
                // Duty bounces between 0 and full scale, one step per period wrap.
                if ((ch[i].mode == MODE_PWM) && wrap[i]) begin
                    if (!dir_dn[i]) begin
                        if (ch[i].duty == PWM_MAX) begin
                            dir_dn[i]   <= 1'b1;
                            ch[i].duty  <= PWM_MAX - PWM_ONE;
                        end else begin
                            ch[i].duty  <= ch[i].duty + PWM_ONE;
                        end
                    end else begin
                        if (ch[i].duty == '0) begin
                            dir_dn[i]   <= 1'b0;
                            ch[i].duty  <= PWM_ONE;
                        end else begin
                            ch[i].duty  <= ch[i].duty - PWM_ONE;
                        end
                    end
                end
`endif

                // A write overrides any same-cycle counter update on its channel.
                if (wr_en && (cfg.cfg_chan == 4'(i))) begin
                    ch[i].mode   <= mode_t'(cfg.cfg_mode);
                    ch[i].period <= cfg.cfg_period;
                    ch[i].duty   <= cfg.cfg_duty;
                    ch[i].cnt    <= '0;
                    ch[i].state  <= 1'b0;
`ifdef LED_BREATHE_EN
                    dir_dn[i]    <= 1'b0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed test of led_pattern_gen: reset, ON/OFF, BLINK timing, PWM duty per frame,
// out-of-range and back-to-back writes, asynchronous reset mid-pattern.
module tb_led_pattern_gen;
    localparam int CHANNELS  = 4;
    localparam int CNT_WIDTH = 24;
    localparam int PWM_WIDTH = 8;

    logic                CLK;
    logic                BTN1;
    logic [CHANNELS-1:0] LED;
    logic                pwm_tick;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    led_pattern_gen_if #(.CNT_WIDTH(CNT_WIDTH), .PWM_WIDTH(PWM_WIDTH)) cfg ();

    led_pattern_gen #(
        .CHANNELS (CHANNELS),
        .CNT_WIDTH(CNT_WIDTH),
        .PWM_WIDTH(PWM_WIDTH)
    ) dut (
        .CLK     (CLK),
        .BTN1    (BTN1),
        .cfg     (cfg.slave),
        .LED     (LED),
        .pwm_tick(pwm_tick)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input int chan, input int mode, input int period, input int duty);
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_chan   = 4'(chan);
        cfg.cfg_mode   = 2'(mode);
        cfg.cfg_period = CNT_WIDTH'(period);
        cfg.cfg_duty   = PWM_WIDTH'(duty);
    endtask

    task automatic count_frame(output int highs);
        highs = 0;
        for (int j = 0; j < 255; j++) begin
            tick();
            if (LED[2]) highs++;
        end
    endtask

    initial begin
        int highs;
        int ticks;
        logic found;
        logic any_led;

        BTN1           = 1'b0;
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_chan   = '0;
        cfg.cfg_mode   = '0;
        cfg.cfg_period = '0;
        cfg.cfg_duty   = '0;

        // Reset held for 4 cycles
        repeat (4) tick();
        chk("rst_led", 32'(LED), 0);
        chk("rst_ready", 32'(cfg.cfg_ready), 0);
        chk("rst_tick", 32'(pwm_tick), 0);
        BTN1   = 1'b1;
        edge_n = 0;
        #2;
        chk("ready_before_edge", 32'(cfg.cfg_ready), 0);
        tick();
        chk("ready_after_edge", 32'(cfg.cfg_ready), 1);

        // ON then OFF on ch0
        wr(0, 1, 0, 0);
        tick();
        chk("on_accept_edge", 32'(LED), 0);
        wr(0, 0, 0, 0);
        tick();
        chk("on_visible", 32'(LED), 32'h1);
        cfg.cfg_valid = 1'b0;
        tick();
        chk("off_visible", 32'(LED), 0);

        // BLINK ch1 period 3: rises k+5, falls k+9, rises k+13
        wr(1, 2, 3, 0);
        tick();
        cfg.cfg_valid = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            tick();
            chk($sformatf("blink_p3_k+%0d", j), 32'(LED[1]), 32'(((j - 1) / 4) % 2));
        end

        // PWM ch2 duty 64: wait for frame boundary, then count one frame
        wr(2, 3, 0, 64);
        tick();
        cfg.cfg_valid = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 300 && !found; j++) begin
            tick();
            if (pwm_tick) found = 1'b1;
        end
        chk("pwm_tick_seen", 32'(found), 1);
        chk("pwm_tick_phase", 32'(edge_n % 255), 0);
        highs = 0;
        ticks = 0;
        for (int j = 0; j < 255; j++) begin
            tick();
            if (LED[2]) highs++;
            if (pwm_tick) ticks++;
        end
        chk("pwm_duty64_highs", 32'(highs), 64);
        chk("pwm_ticks_per_frame", 32'(ticks), 1);
        chk("pwm_tick_at_frame_end", 32'(pwm_tick), 1);

        wr(2, 3, 0, 0);
        tick();
        cfg.cfg_valid = 1'b0;
        count_frame(highs);
        chk("pwm_duty0_highs", 32'(highs), 0);

        wr(2, 3, 0, 255);
        tick();
        cfg.cfg_valid = 1'b0;
        count_frame(highs);
        chk("pwm_duty255_highs", 32'(highs), 255);

        // Out-of-range ch7, then ch3 ON and ch3 BLINK P=0 back to back
        wr(7, 1, 0, 0);
        tick();
        chk("oor_ready", 32'(cfg.cfg_ready), 1);
        chk("oor_no_change", 32'({LED[3], LED[2], LED[0]}), 32'b010);
        wr(3, 1, 0, 0);
        tick();
        chk("b2b_on_accept", 32'(LED[3]), 0);
        wr(3, 2, 0, 0);
        tick();
        cfg.cfg_valid = 1'b0;
        chk("b2b_on_visible", 32'(LED[3]), 1);
        tick();
        chk("b2b_blink_0", 32'(LED[3]), 0);
        tick();
        chk("b2b_blink_1", 32'(LED[3]), 1);
        tick();
        chk("b2b_blink_2", 32'(LED[3]), 0);
        chk("b2b_others", 32'({LED[2], LED[0]}), 32'b10);

        // Asynchronous reset mid-pattern; configuration must be lost
        @(posedge CLK);
        #3;
        BTN1 = 1'b0;
        #1;
        chk("async_rst_led", 32'(LED), 0);
        chk("async_rst_ready", 32'(cfg.cfg_ready), 0);
        repeat (2) tick();
        BTN1 = 1'b1;
        any_led = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            any_led = any_led | (|LED);
        end
        chk("post_rst_leds_off", 32'(any_led), 0);
        chk("post_rst_ready", 32'(cfg.cfg_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
